temp_monitor: RTL and testbench

Self-contained temperature-monitoring subsystem: a behavioural temperature sensor, a sampling/statistics register slave, and a request-driven master joined by an internal single-outstanding bus. A host drives one operation code plus an 8-bit operand; the block completes the transaction and pulses `Done` with the result. It sits below the system controller as the only source of temperature, threshold and alarm state.

---
 rtl/tmon_pkg.sv | 25 ++
 rtl/temp_sensor.sv | 52 +++++
 rtl/temp_monitor.sv | 151 +++++++++++++++
 tb/tb_temp_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmon_pkg.sv
// tmon_pkg: shared operation codes, status bit positions and reset constants
// for the temp_monitor subsystem.
package tmon_pkg;

    typedef logic bool_t;

    typedef enum logic [2:0] {
        NOOP        = 3'd0,
        READ_TEMP   = 3'd1,
        READ_MAX    = 3'd2,
        READ_MIN    = 3'd3,
        SET_HI      = 3'd4,
        SET_LO      = 3'd5,
        READ_STATUS = 3'd6,
        CLEAR       = 3'd7
    } TMON_OP;

    localparam int unsigned STAT_HI    = 0;
    localparam int unsigned STAT_LO    = 1;
    localparam int unsigned STAT_VALID = 2;

    localparam logic [7:0] THRESH_HI_RST = 8'd80;
    localparam logic [7:0] THRESH_LO_RST = 8'd10;

endpackage

// File: rtl/temp_sensor.sv
// temp_sensor: behavioural sensor, a sample-tick divider plus a +/-1
// triangle sweep between TEMP_MIN and TEMP_MAX.
module temp_sensor #(
    parameter int unsigned TICK_DIV  = 4,
    parameter logic [7:0]  TEMP_INIT = 8'd25,
    parameter logic [7:0]  TEMP_MIN  = 8'd0,
    parameter logic [7:0]  TEMP_MAX  = 8'd100
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       tick,
    output logic [7:0] temp
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;
    logic          up;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            temp  <= TEMP_INIT;
            up    <= 1'b1;
        end else begin
            if (tick) count <= '0;
            else      count <= count + 1'b1;

            // Direction flips on the step after a bound is reached, giving 99,100,99.
            if (tick) begin
                if (up) begin
                    if (temp >= TEMP_MAX) begin
                        temp <= temp - 8'd1;
                        up   <= 1'b0;
                    end else begin
                        temp <= temp + 8'd1;
                    end
                end else begin
                    if (temp <= TEMP_MIN) begin
                        temp <= temp + 8'd1;
                        up   <= 1'b1;
                    end else begin
                        temp <= temp - 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/temp_monitor.sv
// temp_monitor: sensor, statistics register slave and request-driven master
// joined by a single-outstanding internal bus. Optional TMON_DEBUG_MON_EN monitor.
module temp_monitor
    import tmon_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 4,
    parameter logic [7:0]  TEMP_INIT = 8'd25,
    parameter logic [7:0]  TEMP_MIN  = 8'd0,
    parameter logic [7:0]  TEMP_MAX  = 8'd100
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] request,
    input  logic [7:0] reqData,
    output logic       Done,
    output logic [7:0] respData,
    output logic       alarm,
    output logic       tick,
    output logic [7:0] temp
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} mst_state_e;

    mst_state_e state, state_next;
    TMON_OP     req_op, op_q;
    logic [7:0] wdata_q;

    bool_t      bus_valid, bus_ack;
    TMON_OP     bus_op;
    logic [7:0] bus_wdata, bus_rdata;

    logic [7:0] sample, max_q, min_q, thresh_hi, thresh_lo, status;
    bool_t      valid, hi_flag, lo_flag;

    temp_sensor #(
        .TICK_DIV (TICK_DIV),
        .TEMP_INIT(TEMP_INIT),
        .TEMP_MIN (TEMP_MIN),
        .TEMP_MAX (TEMP_MAX)
    ) u_sensor (
        .clock  (Clock),
        .reset_n(Reset),
        .tick   (tick),
        .temp   (temp)
    );

    assign req_op    = TMON_OP'(request);
    assign bus_op    = op_q;
    assign bus_wdata = wdata_q;
    assign alarm     = hi_flag | lo_flag;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            op_q     <= NOOP;
            wdata_q  <= '0;
            Done     <= 1'b0;
            respData <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req_op != NOOP) begin
                op_q    <= req_op;
                wdata_q <= reqData;
            end
            // Registered completion keeps Done three edges after the request edge.
            Done <= (state == ST_DONE);
            if (state == ST_DONE) respData <= bus_rdata;
        end
    end

    always_comb begin
        state_next = state;
        bus_valid  = 1'b0;
        case (state)
            ST_IDLE:  if (req_op != NOOP) state_next = ST_ISSUE;
            ST_ISSUE: begin
                bus_valid  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT:  if (bus_ack) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        status             = '0;
        status[STAT_HI]    = hi_flag;
        status[STAT_LO]    = lo_flag;
        status[STAT_VALID] = valid;
    end

    // Op effects are written after the tick update so they win on a shared edge,
    // while reads and threshold compares still see pre-edge register values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sample    <= '0;
            max_q     <= 8'h00;
            min_q     <= 8'hFF;
            valid     <= 1'b0;
            hi_flag   <= 1'b0;
            lo_flag   <= 1'b0;
            thresh_hi <= THRESH_HI_RST;
            thresh_lo <= THRESH_LO_RST;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack <= bus_valid;
            if (tick) begin
                sample <= temp;
                valid  <= 1'b1;
                if (temp > max_q)     max_q   <= temp;
                if (temp < min_q)     min_q   <= temp;
                if (temp > thresh_hi) hi_flag <= 1'b1;
                if (temp < thresh_lo) lo_flag <= 1'b1;
            end
            if (bus_valid) begin
                case (bus_op)
                    READ_TEMP:   bus_rdata <= sample;
                    READ_MAX:    bus_rdata <= max_q;
                    READ_MIN:    bus_rdata <= min_q;
                    SET_HI: begin
                        thresh_hi <= bus_wdata;
                        bus_rdata <= bus_wdata;
                    end
                    SET_LO: begin
                        thresh_lo <= bus_wdata;
                        bus_rdata <= bus_wdata;
                    end
                    READ_STATUS: bus_rdata <= status;
                    CLEAR: begin
                        hi_flag   <= 1'b0;
                        lo_flag   <= 1'b0;
                        max_q     <= tick ? temp : sample;
                        min_q     <= tick ? temp : sample;
                        bus_rdata <= 8'h00;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TMON_DEBUG_MON_EN
    always @(posedge Clock) begin
        if (Reset && Done) $display("[tmon] op=%s operand=%02h resp=%02h", op_q.name(), wdata_q, respData);
        if (Reset && tick) $display("[tmon] sample=%0d", temp);
    end
`endif

endmodule

// File: tb/tb_temp_monitor.sv
// tb_temp_monitor: directed vector table, multi-cycle corner sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_temp_monitor;

    localparam int D = 4;
    localparam logic [2:0] OP_NOOP = 3'd0, OP_RT = 3'd1, OP_RMAX = 3'd2, OP_RMIN = 3'd3,
                           OP_SHI = 3'd4, OP_SLO = 3'd5, OP_RS = 3'd6, OP_CLR = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n, rst2_n;
    logic [2:0] request, req2;
    logic [7:0] reqData, data2;
    logic       Done, alarm, tick, done2, alarm2, tick2;
    logic [7:0] respData, temp, resp2, temp2;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    temp_monitor dut (
        .Clock(clk), .Reset(rst_n), .request(request), .reqData(reqData),
        .Done(Done), .respData(respData), .alarm(alarm), .tick(tick), .temp(temp)
    );

    temp_monitor #(.TICK_DIV(2), .TEMP_MAX(8'd27)) dut2 (
        .Clock(clk), .Reset(rst2_n), .request(req2), .reqData(data2),
        .Done(done2), .respData(resp2), .alarm(alarm2), .tick(tick2), .temp(temp2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: state derived from tick count and op order, not cycle stepping.
    int m_ticks, m_sample, m_max, m_min, m_valid, m_hi, m_lo, m_th_hi, m_th_lo;

    function automatic int tri_val(input int n);
        int span;
        int p;
        span = 100 - 0;
        p = (25 - 0 + n) % (2 * span);
        return (p <= span) ? p : 2 * span - p;
    endfunction

    task automatic m_reset();
        m_ticks = 0; m_sample = 0; m_max = 0; m_min = 255; m_valid = 0;
        m_hi = 0; m_lo = 0; m_th_hi = 80; m_th_lo = 10;
    endtask

    task automatic m_tick();
        m_sample = tri_val(m_ticks);
        m_ticks++;
        m_valid = 1;
        if (m_sample > m_max) m_max = m_sample;
        if (m_sample < m_min) m_min = m_sample;
        if (m_sample > m_th_hi) m_hi = 1;
        if (m_sample < m_th_lo) m_lo = 1;
    endtask

    // Tick edges are e = D-1, 2D-1, ...; floor(e/D) of them lie before edge e.
    task automatic m_sync(input int e);
        while (m_ticks < e / D) m_tick();
    endtask

    task automatic m_op(input logic [2:0] op, input logic [7:0] data, input int e, output int exp);
        m_sync(e);
        exp = 0;
        case (op)
            OP_RT:   exp = m_sample;
            OP_RMAX: exp = m_max;
            OP_RMIN: exp = m_min;
            OP_RS:   exp = m_valid * 4 + m_lo * 2 + m_hi;
            OP_SHI, OP_SLO: exp = data;
            default: exp = 0;
        endcase
        if (e % D == D - 1) m_tick();
        case (op)
            OP_SHI: m_th_hi = data;
            OP_SLO: m_th_lo = data;
            OP_CLR: begin m_hi = 0; m_lo = 0; m_max = m_sample; m_min = m_sample; end
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where Done was seen.
    task automatic run_op(input logic [2:0] op, input logic [7:0] data,
                          output logic [7:0] resp, output int lat, output int e_slave);
        int k;
        k = edge_cnt;
        e_slave = k + 1;
        request = op;
        reqData = data;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            request = OP_NOOP;
            if (Done) begin
                lat = edge_cnt - k;
                break;
            end
        end
        resp = respData;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        int         w;
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] resp;
        logic       alarm;
    } vec_t;

    vec_t vt[17];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int lat, e, exp, cnt, pos;
        int seen[$];
        int tseq[5];
        int texp[5];

        vt[0]  = '{0, OP_RS,   8'h00, 8'h00, 1'b0};
        vt[1]  = '{0, OP_RT,   8'h00, 8'd25, 1'b0};
        vt[2]  = '{0, OP_SHI,  8'd26, 8'd26, 1'b1};
        vt[3]  = '{0, OP_RMAX, 8'h00, 8'd27, 1'b1};
        vt[4]  = '{0, OP_RMIN, 8'h00, 8'd25, 1'b1};
        vt[5]  = '{0, OP_RS,   8'h00, 8'h05, 1'b1};
        vt[6]  = '{0, OP_SHI,  8'hFF, 8'hFF, 1'b1};
        vt[7]  = '{2, OP_CLR,  8'h00, 8'h00, 1'b0};
        vt[8]  = '{0, OP_RMAX, 8'h00, 8'd32, 1'b0};
        vt[9]  = '{0, OP_RMIN, 8'h00, 8'd32, 1'b0};
        vt[10] = '{0, OP_RS,   8'h00, 8'h04, 1'b0};
        vt[11] = '{0, OP_SLO,  8'd200, 8'd200, 1'b0};
        vt[12] = '{0, OP_RS,   8'h00, 8'h04, 1'b1};
        vt[13] = '{0, OP_RS,   8'h00, 8'h06, 1'b1};
        vt[14] = '{0, OP_SLO,  8'd0,  8'd0,  1'b1};
        vt[15] = '{0, OP_CLR,  8'h00, 8'h00, 1'b0};
        vt[16] = '{0, OP_RS,   8'h00, 8'h04, 1'b0};
        texp = '{25, 26, 27, 26, 25};

        rst_n = 1'b0; rst2_n = 1'b0;
        request = OP_NOOP; reqData = '0; req2 = OP_NOOP; data2 = '0;

        repeat (4) @(negedge clk);
        check("reset Done", Done, 0);
        check("reset respData", respData, 0);
        check("reset alarm", alarm, 0);
        check("reset temp", temp, 25);
        check("reset tick", tick, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            repeat (vt[i].w) @(negedge clk);
            run_op(vt[i].op, vt[i].data, r, lat, e);
            check($sformatf("vec%0d latency", i), lat, 4);
            check($sformatf("vec%0d resp", i), r, vt[i].resp);
            check($sformatf("vec%0d alarm", i), alarm, vt[i].alarm);
        end
        @(negedge clk);
        check("Done one-cycle", Done, 0);

        // Held READ_TEMP: sampled at k, k+4, k+8 only.
        do_reset();
        repeat (9) @(negedge clk);
        begin
            int k;
            k = edge_cnt;
            request = OP_RT;
            for (int i = 1; i <= 17; i++) begin
                @(negedge clk);
                if (i == 12) request = OP_NOOP;
                if (Done) begin
                    seen.push_back(i);
                    seen.push_back(respData);
                end
            end
            check("held Done count", seen.size() / 2, 3);
            for (int j = 0; j < 3 && 2 * j + 1 < seen.size(); j++) begin
                m_op(OP_RT, 8'h00, k + 1 + 4 * j, exp);
                check($sformatf("held pos%0d", j), seen[2 * j], 4 + 4 * j);
                check($sformatf("held resp%0d", j), seen[2 * j + 1], exp);
            end
        end

        // Request changed while busy must be ignored.
        begin
            int k;
            k = edge_cnt;
            request = OP_RMAX;
            cnt = 0; pos = 0; r = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i == 1) begin request = OP_SHI; reqData = 8'h00; end
                if (i == 4) request = OP_NOOP;
                if (Done) begin cnt++; pos = i; r = respData; end
            end
            m_op(OP_RMAX, 8'h00, k + 1, exp);
            check("busy Done count", cnt, 1);
            check("busy Done pos", pos, 4);
            check("busy resp", r, exp);
            m_sync(edge_cnt);
            check("busy alarm", alarm, m_hi | m_lo);
        end

        // Randomized transactions against the model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [7:0] d;
            repeat ($urandom_range(0, 12)) @(negedge clk);
            op = 3'($urandom_range(1, 7));
            d = 8'($urandom);
            run_op(op, d, r, lat, e);
            m_op(op, d, e, exp);
            check($sformatf("rnd%0d op%0d latency", i, op), lat, 4);
            check($sformatf("rnd%0d op%0d resp", i, op), r, exp);
            m_sync(edge_cnt);
            check($sformatf("rnd%0d alarm", i), alarm, m_hi | m_lo);
            check($sformatf("rnd%0d temp", i), temp, tri_val(m_ticks));
        end

        // Small sweep instance: 25,26,27,26,25 then reset during WAIT.
        @(negedge clk);
        rst2_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 5; i++) begin
            @(negedge clk);
            if (tick2) begin tseq[cnt] = temp2; cnt++; end
        end
        check("sweep tick count", cnt, 5);
        for (int j = 0; j < 5; j++) check($sformatf("sweep%0d", j), tseq[j], texp[j]);

        req2 = OP_RS;
        cnt = 0;
        for (int i = 0; i < 10 && cnt == 0; i++) begin
            @(negedge clk);
            req2 = OP_NOOP;
            if (done2) cnt++;
        end
        check("dut2 Done seen", cnt, 1);
        check("dut2 status", resp2, 8'h04);

        @(negedge clk);
        req2 = OP_RT;
        @(negedge clk);
        req2 = OP_NOOP;
        @(negedge clk);
        rst2_n = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done2) cnt++;
        end
        check("abort no Done", cnt, 0);
        check("abort respData", resp2, 0);
        check("abort alarm", alarm2, 0);
        check("abort temp", temp2, 25);
        check("abort tick", tick2, 0);
        rst2_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-abort Done", done2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
